// File: rtl/polybius_pkg.sv
// Shared types and helpers for the Polybius code serializer: emitter states,
// ASCII constants and the grid validity check.
package polybius_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TENS,
    ST_UNITS,
    ST_BAD,
    ST_SEP
  } emit_state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] GRID_MIN    = 8'd1;
  localparam logic [7:0] GRID_MAX    = 8'd6;

  typedef struct packed {
    logic       valid;
    logic [7:0] tens;
    logic [7:0] units;
  } code_info_t;

  function automatic code_info_t is_valid_code(input logic [7:0] code);
    code_info_t info;
    info.tens  = code / 8'd10;
    info.units = code % 8'd10;
    info.valid = (info.tens  >= GRID_MIN) && (info.tens  <= GRID_MAX) &&
                 (info.units >= GRID_MIN) && (info.units <= GRID_MAX);
    return info;
  endfunction

endpackage

// File: rtl/polybius_code_fifo.sv
// Synchronous byte FIFO with extra-bit pointers so full and empty are
// distinguished without a separate counter.
module polybius_code_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               data_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == FULL_LVL);
  assign empty_o = (level_o == '0);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/polybius_code_serializer.sv
// Turns buffered Polybius codes into an ASCII digit byte stream with an
// optional separator; off-grid codes become '?' and are counted.
module polybius_code_serializer
  import polybius_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter bit         SEP_EN   = 1'b1,
  parameter logic [7:0] SEP_CHAR = 8'h20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_code,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_char,
  output logic [7:0]             err_count,
  output logic [$clog2(DEPTH):0] fifo_level
);

  emit_state_t state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  err_q, err_d;
  logic [7:0]  out_char_q, out_char_d;
  logic        out_valid_q, out_valid_d;
  logic        wake_q;
  logic        pop, take_next, hs;
  logic [7:0]  fifo_head;
  logic        fifo_full, fifo_empty;
  code_info_t  head_info, hold_info;

  polybius_code_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (in_valid && in_ready),
    .pop_i   (pop),
    .data_i  (in_code),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign in_ready  = !fifo_full;
  assign hs        = out_valid_q && out_ready;
  assign head_info = is_valid_code(fifo_head);

  // An idle emitter waits one cycle after the FIFO turns non-empty before popping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wake_q      <= 1'b0;
      err_q       <= '0;
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
    end else begin
      state_q     <= state_d;
      wake_q      <= !fifo_empty;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_q <= hold_d;
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pop       = 1'b0;
    take_next = 1'b0;
    unique case (state_q)
      ST_IDLE:  pop = wake_q && !fifo_empty;
      ST_TENS:  if (hs) state_d = ST_UNITS;
      ST_UNITS,
      ST_BAD: begin
        if (hs) begin
          if (SEP_EN) state_d = ST_SEP;
          else        take_next = 1'b1;
        end
      end
      ST_SEP:   take_next = hs;
      default:  state_d = ST_IDLE;
    endcase
    // Back-to-back codes pop in the same cycle the previous one finishes.
    if (take_next) begin
      if (!fifo_empty) pop = 1'b1;
      else             state_d = ST_IDLE;
    end
    if (pop) begin
      hold_d  = fifo_head;
      state_d = head_info.valid ? ST_TENS : ST_BAD;
    end
  end

  assign err_d = (pop && !head_info.valid && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

  always_comb begin
    hold_info   = is_valid_code(hold_d);
    out_valid_d = (state_d != ST_IDLE);
    out_char_d  = 8'h00;
    unique case (state_d)
      ST_TENS:  out_char_d = ASCII_ZERO + hold_info.tens;
      ST_UNITS: out_char_d = ASCII_ZERO + hold_info.units;
      ST_BAD:   out_char_d = ASCII_QMARK;
      ST_SEP:   out_char_d = SEP_CHAR;
      default:  out_char_d = 8'h00;
    endcase
  end

  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign err_count = err_q;

endmodule
